// File: rtl/bcp_unit_detect.sv
// Clause-scan stage for the BCP engine: walks the clause list against a snapshot
// of the partial assignment and offers the first unit clause downstream.
module bcp_unit_detect #(
  parameter int unsigned NUM_CLAUSES = 16,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [3:0]        ASSIGNED,
  input  logic [3:0]        VALUE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RD_EN,
  input  logic [15:0]       RDATA,
  output logic              UNIT_VALID,
  input  logic              UNIT_READY,
  output logic [3:0]        UNIT_CLAUSE,
  output logic [7:0]        CLAUSE_TYPE,
  output logic [ADDR_W-1:0] UNIT_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              CONFLICT,
  output logic              NO_UNIT
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    EMIT,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [3:0]        snap_a;
  logic [3:0]        snap_v;

  logic [3:0] clause_mask;
  logic [3:0] clause_pol;
  logic [3:0] free;
  logic [2:0] nfree;
  logic       sat;
  logic       unused_rsvd;

  assign clause_mask = RDATA[11:8];
  assign clause_pol  = RDATA[3:0];
  assign unused_rsvd = ^RDATA[15:12];

  // Classify the clause word currently on RDATA against the snapshot.
  always_comb begin
    sat   = |(clause_mask & snap_a & ~(snap_v ^ clause_pol));
    free  = clause_mask & ~snap_a;
    nfree = 3'(free[0]) + 3'(free[1]) + 3'(free[2]) + 3'(free[3]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      snap_a      <= '0;
      snap_v      <= '0;
      ADDR        <= '0;
      RD_EN       <= 1'b0;
      UNIT_VALID  <= 1'b0;
      UNIT_CLAUSE <= '0;
      CLAUSE_TYPE <= '0;
      UNIT_ADDR   <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      CONFLICT    <= 1'b0;
      NO_UNIT     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            snap_a   <= ASSIGNED;
            snap_v   <= VALUE;
            CONFLICT <= 1'b0;
            NO_UNIT  <= 1'b0;
            cnt      <= '0;
            ADDR     <= '0;
            RD_EN    <= 1'b1;
            BUSY     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          RD_EN <= 1'b0;
          state <= EVAL;
        end
        EVAL: begin
          if (sat || nfree >= 3'd2) begin
            if (cnt == LAST_IDX) begin
              NO_UNIT <= 1'b1;
              DONE    <= 1'b1;
              state   <= FINISH;
            end else begin
              cnt   <= cnt + ADDR_W'(1);
              ADDR  <= cnt + ADDR_W'(1);
              RD_EN <= 1'b1;
              state <= READ;
            end
          end else if (nfree == 3'd0) begin
            CONFLICT <= 1'b1;
            DONE     <= 1'b1;
            state    <= FINISH;
          end else begin
            UNIT_CLAUSE <= free;
            CLAUSE_TYPE <= RDATA[7:0];
            UNIT_ADDR   <= cnt;
            UNIT_VALID  <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (UNIT_READY) begin
            UNIT_VALID <= 1'b0;
            DONE       <= 1'b1;
            state      <= FINISH;
          end
        end
        FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_unit_detect.sv
// Bench for bcp_unit_detect: directed vector table, reset/disturbance sequences and
// randomized scans compared against a per-variable clause model.
module tb_bcp_unit_detect;

  localparam int NUM = 16;
  localparam int AW  = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [3:0]    ASSIGNED = '0;
  logic [3:0]    VALUE = '0;
  logic [AW-1:0] ADDR;
  logic          RD_EN;
  logic [15:0]   RDATA = '0;
  logic          UNIT_VALID;
  logic          UNIT_READY = 1'b0;
  logic [3:0]    UNIT_CLAUSE;
  logic [7:0]    CLAUSE_TYPE;
  logic [AW-1:0] UNIT_ADDR;
  logic          BUSY;
  logic          DONE;
  logic          CONFLICT;
  logic          NO_UNIT;

  bcp_unit_detect #(.NUM_CLAUSES(NUM), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ASSIGNED(ASSIGNED), .VALUE(VALUE),
    .ADDR(ADDR), .RD_EN(RD_EN), .RDATA(RDATA), .UNIT_VALID(UNIT_VALID),
    .UNIT_READY(UNIT_READY), .UNIT_CLAUSE(UNIT_CLAUSE), .CLAUSE_TYPE(CLAUSE_TYPE),
    .UNIT_ADDR(UNIT_ADDR), .BUSY(BUSY), .DONE(DONE), .CONFLICT(CONFLICT),
    .NO_UNIT(NO_UNIT)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [NUM];
  int rd_count = 0;
  int last_rd  = -1;

  // Clause memory: one-cycle read latency, plus a log of issued reads.
  always @(posedge CLK) begin
    if (RD_EN) begin
      RDATA    <= mem[ADDR[3:0]];
      rd_count <= rd_count + 1;
      last_rd  <= int'(ADDR);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] m, input logic [1:0] sz, input logic [3:0] p);
    return {4'h0, m, sz, 2'b00, p};
  endfunction

  // Filler clause that never stops a scan: satisfied if anything is assigned, else 4 free.
  function automatic logic [15:0] filler(input logic [3:0] a, input logic [3:0] v);
    return (a != 4'h0) ? mk(a, 2'b00, v) : mk(4'hF, 2'b00, 4'h0);
  endfunction

  // kind: 0 = no unit, 1 = conflict, 2 = unit
  function automatic void model(input logic [3:0] a, input logic [3:0] v, output int kind,
                                output int k, output logic [3:0] uc, output logic [7:0] ct);
    kind = 0; k = NUM - 1; uc = '0; ct = '0;
    for (int i = 0; i < NUM; i++) begin
      logic [15:0] w;
      int          nf;
      bit          s;
      logic [3:0]  fr;
      w = mem[i]; nf = 0; s = 0; fr = '0;
      for (int j = 0; j < 4; j++) begin
        if (w[8+j]) begin
          if (!a[j]) begin nf++; fr[j] = 1'b1; end
          else if (v[j] == w[j]) s = 1;
        end
      end
      if (!s && nf == 0) begin kind = 1; k = i; return; end
      if (!s && nf == 1) begin kind = 2; k = i; uc = fr; ct = w[7:0]; return; end
    end
  endfunction

  task automatic do_scan(input logic [3:0] a, input logic [3:0] v, input int kind, input int k,
                         input logic [3:0] uc, input logic [7:0] ct, input int rdelay,
                         input bit disturb, input string tag);
    int cyc; bit found; bit busy_ok; int rd0;
    @(negedge CLK);
    ASSIGNED = a; VALUE = v; START = 1'b1; rd0 = rd_count;
    @(posedge CLK); #1;
    START = 1'b0;
    if (disturb) begin ASSIGNED = ~a; VALUE = ~v; end
    cyc = 0; found = 0; busy_ok = 1;
    while (!found && cyc < 200) begin
      @(negedge CLK); cyc++;
      if (disturb) begin START = (cyc == 2); UNIT_READY = (cyc == 2); end
      if (UNIT_VALID || DONE) found = 1;
      else if (!BUSY) busy_ok = 0;
    end
    START = 1'b0; UNIT_READY = 1'b0;
    chk({tag, " event_seen"}, 32'(found), 32'd1);
    if (!found) return;
    chk({tag, " latency"}, 32'(cyc), 32'(2*k + 3));
    chk({tag, " busy_continuous"}, {31'd0, busy_ok & BUSY}, 32'd1);
    chk({tag, " read_count"}, 32'(rd_count - rd0), 32'(k + 1));
    chk({tag, " last_read_addr"}, 32'(last_rd), 32'(k));
    if (kind == 2) begin
      chk({tag, " unit_valid"}, {31'd0, UNIT_VALID}, 32'd1);
      chk({tag, " unit_clause"}, 32'(UNIT_CLAUSE), 32'(uc));
      chk({tag, " clause_type"}, 32'(CLAUSE_TYPE), 32'(ct));
      chk({tag, " unit_addr"}, 32'(UNIT_ADDR), 32'(k));
      chk({tag, " no_done_in_emit"}, {31'd0, DONE}, 32'd0);
      for (int i = 0; i < rdelay; i++) begin
        @(negedge CLK);
        chk({tag, " emit_hold"}, {19'd0, UNIT_VALID, UNIT_CLAUSE, CLAUSE_TYPE},
            {19'd0, 1'b1, uc, ct});
        chk({tag, " emit_hold_addr"}, 32'(UNIT_ADDR), 32'(k));
      end
      UNIT_READY = 1'b1;
      @(posedge CLK); #1;
      UNIT_READY = 1'b0;
      @(negedge CLK);
      chk({tag, " done_after_accept"}, {28'd0, DONE, UNIT_VALID, CONFLICT, NO_UNIT}, 32'b1000);
    end else begin
      chk({tag, " end_flags"}, {28'd0, DONE, UNIT_VALID, CONFLICT, NO_UNIT},
          {28'd0, 1'b1, 1'b0, kind == 1, kind == 0});
    end
    @(negedge CLK);
    chk({tag, " idle_after"}, {28'd0, DONE, BUSY, CONFLICT, NO_UNIT},
        {28'd0, 1'b0, 1'b0, kind == 1, kind == 0});
  endtask

  typedef struct {
    logic [3:0][15:0] c;
    logic [3:0]       a;
    logic [3:0]       v;
    int               kind;
    int               k;
    logic [3:0]       uc;
    logic [7:0]       ct;
    int               rdelay;
    bit               disturb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{c: {mk(4'b1001,2'd0,4'b1001), mk(4'b1001,2'd0,4'b1001), mk(4'b1100,2'd2,4'b0100), mk(4'b0011,2'd0,4'b0011)},
                a: 4'b1001, v: 4'b1001, kind: 2, k: 1, uc: 4'b0100, ct: 8'h84, rdelay: 3, disturb: 0};
    vecs[1] = '{c: {mk(4'b0001,2'd0,4'b0000), mk(4'b0110,2'd2,4'b0110), mk(4'b0010,2'd1,4'b0000), mk(4'b1001,2'd0,4'b0000)},
                a: 4'b0110, v: 4'b0000, kind: 1, k: 2, uc: 4'b0, ct: 8'h0, rdelay: 0, disturb: 0};
    vecs[2] = '{c: {mk(4'b1010,2'd0,4'b0101), mk(4'b1010,2'd0,4'b0101), mk(4'b1010,2'd0,4'b0101), mk(4'b0000,2'd3,4'b1111)},
                a: 4'b1010, v: 4'b0101, kind: 1, k: 0, uc: 4'b0, ct: 8'h0, rdelay: 0, disturb: 0};
    vecs[3] = '{c: {mk(4'b1111,2'd0,4'b0000), mk(4'b1111,2'd0,4'b0000), mk(4'b1111,2'd0,4'b0000), mk(4'b0001,2'd1,4'b0000)},
                a: 4'b0000, v: 4'b0000, kind: 2, k: 0, uc: 4'b0001, ct: 8'h40, rdelay: 0, disturb: 0};
    vecs[4] = '{c: {mk(4'b1111,2'd3,4'b1010), mk(4'b1111,2'd3,4'b1010), mk(4'b1111,2'd3,4'b1010), mk(4'b1111,2'd3,4'b1010)},
                a: 4'b1111, v: 4'b1010, kind: 0, k: NUM-1, uc: 4'b0, ct: 8'h0, rdelay: 0, disturb: 1};
    vecs[5] = '{c: {mk(4'b1110,2'd3,4'b1110), mk(4'b1011,2'd0,4'b1100), mk(4'b1111,2'd0,4'b0000), mk(4'b0011,2'd0,4'b0101)},
                a: 4'b1100, v: 4'b0000, kind: 2, k: 3, uc: 4'b0010, ct: 8'hCE, rdelay: 1, disturb: 1};
    vecs[6] = '{c: {mk(4'b1111,2'd0,4'b0000), mk(4'b1111,2'd0,4'b0000), mk(4'b1111,2'd0,4'b0000), 16'hF131},
                a: 4'b0000, v: 4'b0000, kind: 2, k: 0, uc: 4'b0001, ct: 8'h31, rdelay: 2, disturb: 0};

    for (int i = 0; i < NUM; i++) mem[i] = 16'h0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("reset_outputs", {16'd0, RD_EN, UNIT_VALID, UNIT_CLAUSE, CLAUSE_TYPE, BUSY, DONE},
        32'd0);
    chk("reset_status", {30'd0, CONFLICT, NO_UNIT}, 32'd0);
    chk("reset_addrs", {8'd0, ADDR, UNIT_ADDR}, 32'd0);
    RST = 1'b0;

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NUM; i++) mem[i] = (i < 4) ? vecs[t].c[i] : filler(vecs[t].a, vecs[t].v);
      do_scan(vecs[t].a, vecs[t].v, vecs[t].kind, vecs[t].k, vecs[t].uc, vecs[t].ct,
              vecs[t].rdelay, vecs[t].disturb, $sformatf("vec%0d", t));
    end

    // Reset while a unit is being offered
    begin
      int cyc;
      for (int i = 0; i < NUM; i++) mem[i] = mk(4'hF, 2'd0, 4'h0);
      mem[2] = mk(4'b0100, 2'd1, 4'b0100);
      @(negedge CLK);
      ASSIGNED = 4'h0; VALUE = 4'h0; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      cyc = 0;
      while (!UNIT_VALID && cyc < 100) begin @(negedge CLK); cyc++; end
      chk("rst_emit_reached", {31'd0, UNIT_VALID}, 32'd1);
      RST = 1'b1; #1;
      chk("rst_emit_outputs", {16'd0, RD_EN, UNIT_VALID, UNIT_CLAUSE, CLAUSE_TYPE, BUSY, DONE},
          32'd0);
      chk("rst_emit_rest", {6'd0, ADDR, UNIT_ADDR, CONFLICT, NO_UNIT}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin @(negedge CLK); cyc += int'(DONE) + int'(BUSY); end
      chk("rst_no_done", 32'(cyc), 32'd0);
      do_scan(4'h0, 4'h0, 2, 2, 4'b0100, 8'h44, 0, 0, "after_rst");
    end

    // Randomized scans against the model
    for (int r = 0; r < 40; r++) begin
      logic [3:0] a, v, uc;
      logic [7:0] ct;
      int kind, k;
      for (int i = 0; i < NUM; i++) mem[i] = 16'($urandom);
      a = 4'($urandom); v = 4'($urandom);
      model(a, v, kind, k, uc, ct);
      do_scan(a, v, kind, k, uc, ct, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
              $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
